// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the UART transmit FIFO and its launch sequencer.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } tx_state_e;

  // Cycles spent in S_ACK waiting for the transmitter before the pulse is repeated.
  localparam int ACK_TO = 4;

  typedef logic [1:0] ack_tmr_t;
  localparam ack_tmr_t ACK_TMR_LOAD = ack_tmr_t'(ACK_TO - 1);

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side signal bundle of uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              busy;
  logic              transmit;
  logic [7:0]        tx_byte;
  logic              is_transmitting;

  modport master (
    output wr_en, wr_data, is_transmitting,
    input  full, empty, count, overflow, busy, transmit, tx_byte
  );

  modport slave (
    input  wr_en, wr_data, is_transmitting,
    output full, empty, count, overflow, busy, transmit, tx_byte
  );
endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// DEPTH-entry byte FIFO with registered count/full/empty flags and an overflow pulse.
module uart_byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   count_nxt,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_MAX = DEPTH[ADDR_W:0];

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok;
  logic              pop_ok;

  // Room is judged on the registered count only; a same-cycle pop does not free a slot.
  always_comb begin
    push_ok    = push && !full_q;
    pop_ok     = pop && !empty_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = push && full_q;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data   = mem_q[rptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UartTx transmitter one byte at a time.
//  state   | meaning
//  S_IDLE  | waiting for a byte; pops and loads tx_byte when the FIFO is not empty
//  S_SEND  | transmit pulse high for this single cycle
//  S_ACK   | waiting for is_transmitting to rise; re-pulses after ACK_TO cycles
//  S_DRAIN | transmitter busy with the byte; wait for is_transmitting to fall
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_fifo_if.slave    bus
);

  tx_state_e       state_q, state_d;
  ack_tmr_t        tmr_q, tmr_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            transmit_q, transmit_d;
  logic            busy_q, busy_d;
  logic            pop;
  logic [7:0]      fifo_rd_data;
  logic [ADDR_W:0] fifo_count;
  logic [ADDR_W:0] fifo_count_nxt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_overflow;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.wr_en),
    .pop       (pop),
    .wr_data   (bus.wr_data),
    .rd_data   (fifo_rd_data),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_byte_d = fifo_rd_data;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_ACK;
        tmr_d   = ACK_TMR_LOAD;
      end
      S_ACK: begin
        // The loaded byte stays in tx_byte, so a missed pulse is simply repeated.
        if (bus.is_transmitting)  state_d = S_DRAIN;
        else if (tmr_q == '0)     state_d = S_SEND;
        else                      tmr_d   = tmr_q - ack_tmr_t'(1);
      end
      S_DRAIN: begin
        if (!bus.is_transmitting) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    transmit_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE) || (fifo_count_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      tx_byte_q  <= 8'h00;
      transmit_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = fifo_overflow;
  assign bus.busy     = busy_q;
  assign bus.transmit = transmit_q;
  assign bus.tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small UartTx model (CLOCK_DIVIDE=2, 10-bit frame).
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_uart_tx_fifo;

  localparam int CLOCK_DIVIDE = 2;
  localparam int FRAME_CYC    = 10 * CLOCK_DIVIDE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic       model_en = 1'b1;
  int         bit_cnt;
  logic [7:0] rx_log [$];
  int         pulses  = 0;
  int         b2b_err = 0;
  int         ovl_err = 0;
  logic       prev_tx = 1'b0;

  // UartTx model: accepts a pulse when idle, is_transmitting high for one frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.is_transmitting <= 1'b0;
      bit_cnt             <= 0;
    end else if (!bus.is_transmitting) begin
      if (model_en && bus.transmit === 1'b1) begin
        bus.is_transmitting <= 1'b1;
        bit_cnt             <= FRAME_CYC - 1;
        rx_log.push_back(bus.tx_byte);
      end
    end else if (bit_cnt == 0) begin
      bus.is_transmitting <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (bus.transmit === 1'b1) begin
      pulses <= pulses + 1;
      if (prev_tx) b2b_err <= b2b_err + 1;
      if (bus.is_transmitting === 1'b1) ovl_err <= ovl_err + 1;
    end
    prev_tx <= (bus.transmit === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy !== 1'b0 || bus.is_transmitting !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    `CHK("idle_timeout", (n < budget), 1'b1)
  endtask

  int base;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) step();
    `CHK("rst_count",    bus.count,    5'd0)
    `CHK("rst_empty",    bus.empty,    1'b1)
    `CHK("rst_full",     bus.full,     1'b0)
    `CHK("rst_overflow", bus.overflow, 1'b0)
    `CHK("rst_transmit", bus.transmit, 1'b0)
    `CHK("rst_tx_byte",  bus.tx_byte,  8'h00)
    `CHK("rst_busy",     bus.busy,     1'b0)
    rst_n = 1'b1;
    step();

    // 1: single byte, pulse in the third cycle counting the write cycle
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    `CHK("t1_count_after_wr", bus.count,    5'd1)
    `CHK("t1_no_early_tx",    bus.transmit, 1'b0)
    step();
    `CHK("t1_transmit",       bus.transmit, 1'b1)
    `CHK("t1_tx_byte",        bus.tx_byte,  8'hA5)
    `CHK("t1_empty_after_pop", bus.empty,   1'b1)
    step();
    `CHK("t1_pulse_1cycle",   bus.transmit, 1'b0)
    `CHK("t1_pulse_count",    pulses,       1)
    `CHK("t1_is_tx",          bus.is_transmitting, 1'b1)

    // 2: burst of 16 while the sequencer is draining A5 -> FIFO fills
    for (int i = 1; i <= 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
    `CHK("t2_full",  bus.full,  1'b1)
    `CHK("t2_count", bus.count, 5'd16)

    // 3: overflow while full
    bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
    step();
    bus.wr_en = 1'b0;
    `CHK("t3_overflow_hi", bus.overflow, 1'b1)
    `CHK("t3_count_held",  bus.count,    5'd16)
    step();
    `CHK("t3_overflow_lo", bus.overflow, 1'b0)
    `CHK("t3_count_held2", bus.count,    5'd16)
    wait_idle(2000);
    `CHK("t2_rx_size", rx_log.size(), 17)
    if (rx_log.size() == 17) begin
      `CHK("t2_rx_first", rx_log[0], 8'hA5)
      for (int i = 1; i <= 16; i++) `CHK("t2_rx_order", rx_log[i], 8'(i))
    end
    `CHK("t2_pulses", pulses, 17)
    `CHK("t2_empty",  bus.empty, 1'b1)

    // 4: three drained rounds of 12 -> pointers wrap
    rx_log.delete();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + r * 16 + i);
        step();
      end
      bus.wr_en = 1'b0;
      wait_idle(2000);
    end
    `CHK("t4_rx_size", rx_log.size(), 36)
    if (rx_log.size() == 36) begin
      for (int r = 0; r < 3; r++)
        for (int i = 0; i < 12; i++)
          `CHK("t4_rx_order", rx_log[r * 12 + i], 8'(8'h20 + r * 16 + i))
    end

    // 5: lost ack -> re-pulse every 5 cycles, then release the model
    rx_log.delete();
    base     = pulses;
    model_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 8'h5C;
    step();
    bus.wr_en = 1'b0;
    step();
    `CHK("t5_pulse0",     bus.transmit, 1'b1)
    `CHK("t5_byte0",      bus.tx_byte,  8'h5C)
    step();
    `CHK("t5_gap_a",      bus.transmit, 1'b0)
    repeat (3) step();
    `CHK("t5_gap_b",      bus.transmit, 1'b0)
    step();
    `CHK("t5_pulse1",     bus.transmit, 1'b1)
    `CHK("t5_byte1",      bus.tx_byte,  8'h5C)
    repeat (5) step();
    `CHK("t5_pulse2",     bus.transmit, 1'b1)
    `CHK("t5_byte2",      bus.tx_byte,  8'h5C)
    model_en = 1'b1;
    wait_idle(500);
    `CHK("t5_rx_size",    rx_log.size(), 1)
    if (rx_log.size() == 1) `CHK("t5_rx_byte", rx_log[0], 8'h5C)
    `CHK("t5_pulses",     pulses - base, 3)

    // 6: reset while draining with five bytes queued
    rx_log.delete();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h61 + i);
      step();
    end
    bus.wr_en = 1'b0;
    `CHK("t6_count_pre",   bus.count,   5'd5)
    `CHK("t6_tx_byte_pre", bus.tx_byte, 8'h61)
    `CHK("t6_is_tx_pre",   bus.is_transmitting, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    `CHK("t6_count_rst",    bus.count,    5'd0)
    `CHK("t6_empty_rst",    bus.empty,    1'b1)
    `CHK("t6_transmit_rst", bus.transmit, 1'b0)
    `CHK("t6_tx_byte_rst",  bus.tx_byte,  8'h00)
    `CHK("t6_busy_rst",     bus.busy,     1'b0)
    step();
    step();
    rst_n = 1'b1;
    base  = pulses;
    repeat (10) step();
    `CHK("t6_no_tx_after",  pulses - base, 0)
    `CHK("t6_empty_after",  bus.empty,     1'b1)

    `CHK("mon_back_to_back",   b2b_err, 0)
    `CHK("mon_tx_while_busy",  ovl_err, 0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`undef CHK
